// File: rtl/if_stage_if.sv
// -----------------------------------------------------------------------------
// if_stage_if -- instruction memory bus between the fetch stage and memory.
//
// Signals
//   req   : fetch request, held with addr until ready is seen high
//   addr  : word-aligned fetch address
//   ready : memory accepts the request and returns rdata in the same cycle
//   rdata : instruction word, meaningful when req and ready are both high
//
// Modports
//   master : fetch stage side (drives req/addr)
//   slave  : memory side (drives ready/rdata)
// -----------------------------------------------------------------------------
interface if_stage_if #(
  parameter int WORD_WIDTH = 32
);
  logic                  req;
  logic [WORD_WIDTH-1:0] addr;
  logic                  ready;
  logic [WORD_WIDTH-1:0] rdata;

  modport master (output req, addr, input  ready, rdata);
  modport slave  (input  req, addr, output ready, rdata);
endinterface

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage -- instruction fetch stage with a two-entry fetch buffer.
//
// Fetches sequential words from instruction memory, queues them as
// {fetch address + PC_STEP, instruction} and presents the oldest entry to
// decode. A branch flushes the buffer and redirects fetching; a response
// that was already in flight when the branch arrived is drained and dropped.
//
// Ports
//   clk             : clock, rising edge
//   rst             : asynchronous active-low reset
//   freeze          : decode hold, the presented entry is not consumed
//   branch_taken    : one-cycle redirect pulse (overrides freeze)
//   branch_address  : redirect target, bits [1:0] ignored
//   imem            : instruction memory bus (master side)
//   valid_out       : head entry is valid
//   pc_out          : head entry fetch address + PC_STEP
//   instruction_out : head entry instruction word
//
// Only BUF_DEPTH = 2 is supported.
// -----------------------------------------------------------------------------
module if_stage #(
  parameter int WORD_WIDTH = 32,
  parameter int PC_STEP    = 4,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  branch_taken,
  input  logic [WORD_WIDTH-1:0] branch_address,
  if_stage_if.master            imem,
  output logic                  valid_out,
  output logic [WORD_WIDTH-1:0] pc_out,
  output logic [WORD_WIDTH-1:0] instruction_out
);

  localparam logic [WORD_WIDTH-1:0] STEP = WORD_WIDTH'(PC_STEP);
  localparam logic [1:0]            FULL = 2'(BUF_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  typedef struct packed {
    logic [WORD_WIDTH-1:0] pc;
    logic [WORD_WIDTH-1:0] instr;
  } entry_t;

  state_t                state, state_next;
  entry_t                fifo [2];
  entry_t                last_q;      // last entry shown, held while empty
  logic                  rd_ptr, wr_ptr;
  logic [1:0]            count, count_next;
  logic [WORD_WIDTH-1:0] fetch_pc;
  logic [WORD_WIDTH-1:0] drop_addr;   // address of the response being dropped
  logic [WORD_WIDTH-1:0] branch_target;
  logic                  push, pop;

  assign branch_target = branch_address & ~WORD_WIDTH'(3);
  assign valid_out     = (count != 2'd0);

  // A branch cycle neither keeps returned data nor consumes the head.
  assign push = (state == REQ) && imem.ready && !branch_taken;
  assign pop  = valid_out && !freeze && !branch_taken;

  always_comb begin
    count_next = count + 2'(push) - 2'(pop);
    if (branch_taken) count_next = 2'd0;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (!rst) state <= REQ;
    else      state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. REQ only stays active while the buffer has room after
  // this cycle's push/pop, so a push never lands on a full buffer.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
    state_next = state;
    unique case (state)
      IDLE: if (count_next < FULL) state_next = REQ;
      REQ: begin
        if (branch_taken)    state_next = imem.ready ? REQ : DROP;
        else if (imem.ready) state_next = (count_next < FULL) ? REQ : IDLE;
      end
      DROP: if (imem.ready) state_next = REQ;
      default: state_next = REQ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. Reset parks the FSM in REQ so the first fetch goes out on
  // the first edge after release; gating with rst keeps the bus idle in reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    imem.req  = 1'b0;
    imem.addr = fetch_pc;
    case (state)
      REQ:  imem.req = rst;
      DROP: begin
        imem.req  = rst;
        imem.addr = drop_addr;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: fetch PC, buffer, pointers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc  <= '0;
      drop_addr <= '0;
      count     <= 2'd0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      // NOTE: buffer slots are reset because the head must read as zero
      // straight out of reset; deeper storage would normally stay unreset.
      fifo[0]   <= '0;
      fifo[1]   <= '0;
      last_q    <= '0;
    end else begin
      count <= count_next;
      if (valid_out) last_q <= fifo[rd_ptr];
      if (branch_taken) begin
        fetch_pc <= branch_target;
        wr_ptr   <= rd_ptr;  // flush: empty buffer, head position unchanged
        // Remember the unanswered address so it stays on the bus until ready.
        if (state == REQ && !imem.ready) drop_addr <= fetch_pc;
      end else begin
        if (push) begin
          fifo[wr_ptr] <= '{pc: fetch_pc + STEP, instr: imem.rdata};
          wr_ptr       <= ~wr_ptr;
          fetch_pc     <= fetch_pc + STEP;
        end
        if (pop) rd_ptr <= ~rd_ptr;
      end
    end
  end

  // Empty buffer shows the last presented entry rather than a stale slot.
  assign pc_out          = valid_out ? fifo[rd_ptr].pc    : last_q.pc;
  assign instruction_out = valid_out ? fifo[rd_ptr].instr : last_q.instr;

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage -- self-checking bench for if_stage.
// Directed table of cycle vectors, a reset-in-flight sequence, then random
// freeze/ready/branch traffic compared against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_if_stage;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         freeze = 1'b0;
  logic         branch_taken = 1'b0;
  logic [W-1:0] branch_address = '0;
  logic         valid_out;
  logic [W-1:0] pc_out;
  logic [W-1:0] instruction_out;

  if_stage_if #(.WORD_WIDTH(W)) bus ();

  if_stage #(.WORD_WIDTH(W), .PC_STEP(4), .BUF_DEPTH(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .freeze          (freeze),
    .branch_taken    (branch_taken),
    .branch_address  (branch_address),
    .imem            (bus),
    .valid_out       (valid_out),
    .pc_out          (pc_out),
    .instruction_out (instruction_out)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed function of the address.
  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  assign bus.rdata = mem_word(bus.addr);
  initial bus.ready = 1'b0;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the buffer is a queue of delivered-in-order entries; the
  // fetch stream is a pointer that advances on kept responses and jumps on
  // branches; an outstanding request caught by a branch is remembered and its
  // response discarded.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [W-1:0] pc;
    logic [W-1:0] ins;
  } ent_t;

  ent_t         q[$];
  ent_t         m_last;
  logic [W-1:0] m_fetch;
  logic [W-1:0] m_drop_addr;
  bit           m_drop;

  task automatic model_reset();
    q.delete();
    m_fetch     = '0;
    m_drop      = 1'b0;
    m_drop_addr = '0;
    m_last      = '{pc: '0, ins: '0};
  endtask

  task automatic model_check();
    bit want_req;
    want_req = (q.size() < 2);
    check_b("m_valid", valid_out, q.size() != 0);
    if (q.size() != 0) m_last = q[0];
    check("m_pc", pc_out, m_last.pc);
    check("m_ins", instruction_out, m_last.ins);
    check_b("m_req", bus.req, want_req);
    if (want_req) check("m_addr", bus.addr, m_drop ? m_drop_addr : m_fetch);
  endtask

  task automatic drive(input bit f, input bit r, input bit b, input logic [W-1:0] ba);
    freeze         = f;
    bus.ready      = r;
    branch_taken   = b;
    branch_address = ba;
    #2;
  endtask

  // Advance the model by this cycle's inputs, clock, then compare.
  task automatic tick();
    bit           req_e;
    bit           pop_e;
    logic [W-1:0] cur;
    req_e = (q.size() < 2);
    pop_e = (q.size() != 0) && !freeze && !branch_taken;
    cur   = m_fetch;
    if (pop_e) void'(q.pop_front());
    if (branch_taken) begin
      if (m_drop && bus.ready) m_drop = 1'b0;
      else if (req_e && !bus.ready && !m_drop) begin
        m_drop      = 1'b1;
        m_drop_addr = cur;
      end
      q.delete();
      m_fetch = branch_address & ~32'h3;
    end else if (req_e && bus.ready) begin
      if (m_drop) m_drop = 1'b0;
      else begin
        q.push_back('{pc: cur + 32'd4, ins: mem_word(cur)});
        m_fetch = cur + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    model_check();
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors: inputs for one cycle plus the outputs seen in that cycle.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit           frz, rdy, br;
    logic [W-1:0] ba;
    bit           e_req;
    logic [W-1:0] e_addr;
    bit           e_valid;
    logic [W-1:0] e_pc, e_ins;
  } vec_t;

  function automatic vec_t mk(input bit f, input bit r, input bit b, input logic [W-1:0] ba,
                              input bit er, input logic [W-1:0] ea,
                              input bit ev, input logic [W-1:0] ep, input logic [W-1:0] ei);
    vec_t v;
    v.frz = f; v.rdy = r; v.br = b; v.ba = ba;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_ins = ei;
    return v;
  endfunction

  vec_t tbl[28];

  logic         r_b;
  logic [W-1:0] r_ba;

  initial begin
    // Streaming from reset, ready always high.
    tbl[0]  = mk(0, 1, 0, 0,      1, 32'h0,   0, 32'h0,   32'h0);
    tbl[1]  = mk(0, 1, 0, 0,      1, 32'h4,   1, 32'h4,   mem_word(32'h0));
    tbl[2]  = mk(0, 1, 0, 0,      1, 32'h8,   1, 32'h8,   mem_word(32'h4));
    tbl[3]  = mk(0, 1, 0, 0,      1, 32'hC,   1, 32'hC,   mem_word(32'h8));
    // Freeze for five cycles: buffer fills, requests stop, head holds.
    tbl[4]  = mk(1, 1, 0, 0,      1, 32'h10,  1, 32'h10,  mem_word(32'hC));
    tbl[5]  = mk(1, 1, 0, 0,      0, 32'h0,   1, 32'h10,  mem_word(32'hC));
    tbl[6]  = mk(1, 1, 0, 0,      0, 32'h0,   1, 32'h10,  mem_word(32'hC));
    tbl[7]  = mk(1, 1, 0, 0,      0, 32'h0,   1, 32'h10,  mem_word(32'hC));
    tbl[8]  = mk(1, 1, 0, 0,      0, 32'h0,   1, 32'h10,  mem_word(32'hC));
    tbl[9]  = mk(0, 1, 0, 0,      0, 32'h0,   1, 32'h10,  mem_word(32'hC));
    tbl[10] = mk(0, 1, 0, 0,      1, 32'h14,  1, 32'h14,  mem_word(32'h10));
    tbl[11] = mk(0, 1, 0, 0,      1, 32'h18,  1, 32'h18,  mem_word(32'h14));
    // Branch to 0x10 with data returning (dropped), then stall at 0x10 and
    // redirect to 0x103 while the request is outstanding.
    tbl[12] = mk(0, 1, 1, 32'h10, 1, 32'h1C,  1, 32'h1C,  mem_word(32'h18));
    tbl[13] = mk(0, 0, 0, 0,      1, 32'h10,  0, 32'h1C,  mem_word(32'h18));
    tbl[14] = mk(0, 0, 0, 0,      1, 32'h10,  0, 32'h1C,  mem_word(32'h18));
    tbl[15] = mk(0, 0, 1, 32'h103,1, 32'h10,  0, 32'h1C,  mem_word(32'h18));
    tbl[16] = mk(0, 0, 0, 0,      1, 32'h10,  0, 32'h1C,  mem_word(32'h18));
    tbl[17] = mk(0, 1, 0, 0,      1, 32'h10,  0, 32'h1C,  mem_word(32'h18));
    tbl[18] = mk(0, 1, 0, 0,      1, 32'h100, 0, 32'h1C,  mem_word(32'h18));
    tbl[19] = mk(0, 1, 0, 0,      1, 32'h104, 1, 32'h104, mem_word(32'h100));
    // Fill under freeze, then branch to 0x100 with freeze still high.
    tbl[20] = mk(1, 1, 0, 0,      1, 32'h108, 1, 32'h108, mem_word(32'h104));
    tbl[21] = mk(1, 1, 1, 32'h100,0, 32'h0,   1, 32'h108, mem_word(32'h104));
    tbl[22] = mk(0, 1, 0, 0,      1, 32'h100, 0, 32'h108, mem_word(32'h104));
    tbl[23] = mk(0, 1, 0, 0,      1, 32'h104, 1, 32'h104, mem_word(32'h100));
    // Branch to the top word; fetch address wraps to 0.
    tbl[24] = mk(0, 1, 1, 32'hFFFF_FFFF, 1, 32'h108, 1, 32'h108, mem_word(32'h104));
    tbl[25] = mk(0, 1, 0, 0,      1, 32'hFFFF_FFFC, 0, 32'h108, mem_word(32'h104));
    tbl[26] = mk(0, 1, 0, 0,      1, 32'h0,   1, 32'h0,   mem_word(32'hFFFF_FFFC));
    tbl[27] = mk(0, 1, 0, 0,      1, 32'h4,   1, 32'h4,   mem_word(32'h0));

    // Reset values while reset is held.
    repeat (2) @(posedge clk);
    #1;
    check_b("reset_valid", valid_out, 1'b0);
    check("reset_pc", pc_out, '0);
    check("reset_ins", instruction_out, '0);
    check_b("reset_req", bus.req, 1'b0);
    model_reset();
    #2;
    rst = 1'b1;

    for (int i = 0; i < 28; i++) begin
      drive(tbl[i].frz, tbl[i].rdy, tbl[i].br, tbl[i].ba);
      check_b($sformatf("vec%0d_req", i), bus.req, tbl[i].e_req);
      if (tbl[i].e_req) check($sformatf("vec%0d_addr", i), bus.addr, tbl[i].e_addr);
      check_b($sformatf("vec%0d_valid", i), valid_out, tbl[i].e_valid);
      check($sformatf("vec%0d_pc", i), pc_out, tbl[i].e_pc);
      check($sformatf("vec%0d_ins", i), instruction_out, tbl[i].e_ins);
      tick();
    end

    // Reset in the middle of a request with one buffered entry.
    #2;
    rst = 1'b0;
    #1;
    check_b("midrst_valid", valid_out, 1'b0);
    check("midrst_pc", pc_out, '0);
    check("midrst_ins", instruction_out, '0);
    check_b("midrst_req", bus.req, 1'b0);
    model_reset();
    #1;
    rst = 1'b1;
    drive(0, 1, 0, 0);
    check_b("restart_req", bus.req, 1'b1);
    check("restart_addr", bus.addr, '0);
    tick();
    check("restart_pc", pc_out, 32'h4);
    check("restart_ins", instruction_out, mem_word(32'h0));

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      r_b  = ($urandom_range(0, 99) < 8);
      r_ba = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                         : ($urandom & 32'h0000_0FFF);
      drive($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 65, r_b, r_ba);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter WORD_WIDTH, default 32, instruction, PC and address width.
REQ-002 Parameter PC_STEP, default 4, byte increment between sequential fetches.
REQ-003 Parameter BUF_DEPTH, default 2, fetch buffer entries; only value 2 is supported.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 freeze  input  1  downstream hazard hold; the presented entry is not consumed.
REQ-007 branch_taken  input  1  one-cycle redirect pulse from execute.
REQ-008 branch_address  input  WORD_WIDTH  redirect target; bits [1:0] ignored, treated as 0.
REQ-009 imem_req  output  1  instruction memory request.
REQ-010 imem_addr  output  WORD_WIDTH  word-aligned fetch address.
REQ-011 imem_ready  input  1  memory accepts the request and returns data in the same cycle.
REQ-012 imem_rdata  input  WORD_WIDTH  instruction word; valid when imem_req and imem_ready are both high.
REQ-013 valid_out  output  1  buffer head is presented to decode.
REQ-014 pc_out  output  WORD_WIDTH  fetch address of the head entry plus PC_STEP.
REQ-015 instruction_out  output  WORD_WIDTH  head entry instruction word.

Function
REQ-016 The stage SHALL hold fetch_pc, a 2-entry FIFO of {addr+PC_STEP, instruction}, a 2-bit count (0..2) and FSM states IDLE, REQ and DROP.
REQ-017 imem_req SHALL be 1 exactly in REQ and DROP; imem_addr SHALL equal fetch_pc in REQ and the latched in-flight address in DROP.
REQ-018 imem_req and imem_addr SHALL stay stable from assertion until the cycle imem_ready is high.
REQ-019 IDLE->REQ SHALL occur when count<2 after this cycle's push/pop; otherwise the FSM stays in IDLE.
REQ-020 In REQ with imem_ready=1 and no branch: push {fetch_pc+PC_STEP, imem_rdata}, fetch_pc += PC_STEP, go to REQ if resulting count<2, else IDLE.
REQ-021 A pop SHALL occur when valid_out=1, freeze=0 and branch_taken=0; a pop advances the head.
REQ-022 A simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-023 valid_out SHALL equal (count!=0); pc_out and instruction_out SHALL show the head entry and hold their values while freeze=1.
REQ-024 When valid_out=0, pc_out and instruction_out SHALL keep their last values.
REQ-025 With freeze=1 and count=2, no request SHALL be issued; no entry is ever overwritten.
REQ-026 branch_taken=1 SHALL override freeze, clear count to 0 (valid_out=0 next cycle), and load fetch_pc with branch_address & ~3.
REQ-027 Branch in REQ with imem_ready=1: returned data discarded, next state REQ at the new fetch_pc.
REQ-028 Branch in REQ with imem_ready=0: next state DROP, in-flight address held.
REQ-029 In DROP, the response SHALL be discarded on imem_ready=1, followed by REQ at fetch_pc.
REQ-030 Branch in DROP SHALL update fetch_pc only; state stays DROP.
REQ-031 Branch in IDLE SHALL go to REQ at the new fetch_pc next cycle.
REQ-032 fetch_pc arithmetic SHALL be modulo 2^WORD_WIDTH; 0xFFFFFFFC+4 wraps to 0.
REQ-033 Minimum latency from imem_ready acceptance to valid_out SHALL be 1 cycle.

Reset
REQ-034 rst=0 SHALL asynchronously force: state REQ, fetch_pc=0, count=0, FIFO heads=0, valid_out=0, pc_out=0, instruction_out=0.
REQ-035 imem_req SHALL be 0 while rst=0 and 1 from the first clock edge after release, with imem_addr=0.
REQ-036 Reset asserted mid-request or in DROP SHALL abandon the transaction; no data is pushed after release except from new requests.

Verification
REQ-037 Reset release, imem_ready=1 constant, freeze=0 -> imem_addr 0,4,8…; one cycle later valid_out=1, pc_out 4,8,12… with matching instructions.
REQ-038 freeze=1 for 5 cycles with ready=1 -> count reaches 2, imem_req=0, pc_out/instruction_out hold; release -> in-order delivery with no loss or duplication.
REQ-039 imem_ready held 0 for 3 cycles at addr 0x10, branch_taken pulse to 0x103 -> DROP; imem_addr stays 0x10 until ready; next request addr 0x100; 0x10 data never seen at valid_out.
REQ-040 branch_taken with freeze=1 and count=2 -> valid_out=0 next cycle; first valid pc_out=0x104 for branch target 0x100.
REQ-041 fetch_pc forced to 0xFFFFFFFC by branch -> fetches 0xFFFFFFFC, then 0x0; pc_out 0x0 then 0x4.
REQ-042 rst pulsed low while in REQ with count=1 -> immediate valid_out=0, pc_out=0; restart at addr 0.
